// File: rtl/ctrl_pkg.sv
// Shared definitions for the burst command controller.
// Holds the FSM state encoding and the default key patterns used by the
// key decoder and the top-level controller. No ports.
package ctrl_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_MEM_RD = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_MEM_WR = 3'd4;
    localparam state_t ST_NEXT   = 3'd5;

    localparam int         DEF_KEY_LEN = 4;
    localparam logic [3:0] DEF_KEY_MEM = 4'b1011;
    localparam logic [3:0] DEF_KEY_DIR = 4'b1001;
    localparam logic [3:0] DEF_KEY_OFF = 4'b0000;

endpackage

// File: rtl/key_match_decoder.sv
// Serial key decoder.
// Shifts qualified key bits into a KEY_LEN-bit register and compares the
// post-shift value against three patterns, registering ACTIVE/MODE.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_bit        : serial key bit, sampled when key_valid=1
//   key_valid      : qualifies key_bit
//   active, mode   : registered unlock state and memory/direct selection
module key_match_decoder
    import ctrl_pkg::*;
#(
    parameter int                 KEY_LEN = DEF_KEY_LEN,
    parameter logic [KEY_LEN-1:0] KEY_MEM = DEF_KEY_MEM,
    parameter logic [KEY_LEN-1:0] KEY_DIR = DEF_KEY_DIR,
    parameter logic [KEY_LEN-1:0] KEY_OFF = DEF_KEY_OFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_bit,
    input  logic key_valid,
    output logic active,
    output logic mode
);

    logic [KEY_LEN-1:0] shift_q, shift_d, shifted;
    logic               active_q, active_d;
    logic               mode_q, mode_d;

    always_comb begin
        shifted  = {shift_q[KEY_LEN-2:0], key_bit};
        shift_d  = shift_q;
        active_d = active_q;
        mode_d   = mode_q;
        if (key_valid) begin
            shift_d = shifted;
            if (shifted == KEY_MEM) begin
                active_d = 1'b1;
                mode_d   = 1'b1;
                shift_d  = '0;
            end else if (shifted == KEY_DIR) begin
                active_d = 1'b1;
                mode_d   = 1'b0;
                shift_d  = '0;
            end else if (shifted == KEY_OFF) begin
                // Register keeps KEY_OFF; another zero re-matches OFF, which is idempotent.
                active_d = 1'b0;
                mode_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            active_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            active_q <= active_d;
            mode_q   <= mode_d;
        end
    end

    assign active = active_q;
    assign mode   = mode_q;

endmodule

// File: rtl/ctrl_burst_controller.sv
// Burst command controller between the command decoder, memory and the
// parallel-load Tx serializer.
// Ports:
//   CLK, RESET_N             : clock, asynchronous active-low reset
//   INPUT_KEY, KEY_VALID     : serial unlock key stream
//   VALID_CMD, RW            : command strobe and direction (1=write)
//   START_ADDR, BURST_LEN    : first address and word count (0 = 2^BURST_W)
//   Tx_DONE                  : serializer idle level
//   ACTIVE, MODE             : unlock state, 1=memory / 0=direct mode
//   ACCESS_MEM, RW_MEM       : memory strobe and direction
//   MEM_ADDR                 : current burst address
//   PARALLEL_LOAD, Tx_DATA   : serializer load / start transmit
//   BUSY                     : transaction in progress
//   ERROR                    : sticky Tx_DONE timeout flag
module ctrl_burst_controller
    import ctrl_pkg::*;
#(
    parameter int                 ADDR_W  = 8,
    parameter int                 BURST_W = 4,
    parameter int                 KEY_LEN = DEF_KEY_LEN,
    parameter logic [KEY_LEN-1:0] KEY_MEM = DEF_KEY_MEM,
    parameter logic [KEY_LEN-1:0] KEY_DIR = DEF_KEY_DIR,
    parameter logic [KEY_LEN-1:0] KEY_OFF = DEF_KEY_OFF,
    parameter int                 TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              INPUT_KEY,
    input  logic              KEY_VALID,
    input  logic              VALID_CMD,
    input  logic              RW,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [BURST_W-1:0] BURST_LEN,
    input  logic              Tx_DONE,
    output logic              ACTIVE,
    output logic              MODE,
    output logic              ACCESS_MEM,
    output logic              RW_MEM,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              PARALLEL_LOAD,
    output logic              Tx_DATA,
    output logic              BUSY,
    output logic              ERROR
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [BURST_W:0]  REM_ONE  = (BURST_W + 1)'(1);

    logic active, mode;

    key_match_decoder #(
        .KEY_LEN (KEY_LEN),
        .KEY_MEM (KEY_MEM),
        .KEY_DIR (KEY_DIR),
        .KEY_OFF (KEY_OFF)
    ) u_key (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .key_bit   (INPUT_KEY),
        .key_valid (KEY_VALID),
        .active    (active),
        .mode      (mode)
    );

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BURST_W:0]  rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              cmd_mode_q, cmd_mode_d;
    logic              cmd_rw_q, cmd_rw_d;
    logic              error_q, error_d;
    logic              access_q, access_d;
    logic              rw_mem_q, rw_mem_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              abort;

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            cmd_mode_q <= 1'b0;
            cmd_rw_q   <= 1'b0;
            error_q    <= 1'b0;
            access_q   <= 1'b0;
            rw_mem_q   <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            cmd_mode_q <= cmd_mode_d;
            cmd_rw_q   <= cmd_rw_d;
            error_q    <= error_d;
            access_q   <= access_d;
            rw_mem_q   <= rw_mem_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tmo_d      = '0;
        cmd_mode_d = cmd_mode_q;
        cmd_rw_d   = cmd_rw_q;
        error_d    = error_q;

        // Losing the key, or switching mode, kills whatever transaction is running.
        abort = (state_q != ST_IDLE) && (!active || (mode != cmd_mode_q));

        case (state_q)
            ST_IDLE: begin
                if (VALID_CMD && active) begin
                    if (mode && (RW || Tx_DONE)) begin
                        error_d    = 1'b0;
                        cmd_mode_d = 1'b1;
                        cmd_rw_d   = RW;
                        addr_d     = START_ADDR;
                        rem_d      = (BURST_LEN == '0) ? {1'b1, {BURST_W{1'b0}}}
                                                       : {1'b0, BURST_LEN};
                        state_d    = RW ? ST_MEM_WR : ST_MEM_RD;
                    end else if (!mode && Tx_DONE) begin
                        error_d    = 1'b0;
                        cmd_mode_d = 1'b0;
                        cmd_rw_d   = 1'b0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_MEM_WR: state_d = ST_NEXT;
            ST_MEM_RD: state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_WAIT;
            ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (Tx_DONE) begin
                    state_d = cmd_mode_q ? ST_NEXT : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_NEXT: begin
                // Address/count advance once, on leaving NEXT, so a read burst
                // can sit here waiting for Tx_DONE without over-counting.
                if (rem_q == REM_ONE) begin
                    rem_d   = rem_q - REM_ONE;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end else if (cmd_rw_q) begin
                    rem_d   = rem_q - REM_ONE;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_MEM_WR;
                end else if (Tx_DONE) begin
                    rem_d   = rem_q - REM_ONE;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_MEM_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            error_d = error_q;
            tmo_d   = '0;
        end
    end

    // Output decode from the next state, so registered outputs line up with state_q
    always_comb begin
        access_d = (state_d == ST_MEM_WR) || (state_d == ST_MEM_RD);
        rw_mem_d = (state_d == ST_MEM_WR);
        load_d   = (state_d == ST_LOAD);
        busy_d   = (state_d != ST_IDLE);
    end

    assign ACTIVE        = active;
    assign MODE          = mode;
    assign ACCESS_MEM    = access_q;
    assign RW_MEM        = rw_mem_q;
    assign MEM_ADDR      = addr_q;
    assign PARALLEL_LOAD = load_q;
    assign Tx_DATA       = load_q;
    assign BUSY          = busy_q;
    assign ERROR         = error_q;

endmodule

// File: tb/tb_ctrl_burst_controller.sv
// Directed self-checking bench for ctrl_burst_controller.
module tb_ctrl_burst_controller;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       INPUT_KEY, KEY_VALID, VALID_CMD, RW, Tx_DONE;
    logic [7:0] START_ADDR;
    logic [3:0] BURST_LEN;
    logic       ACTIVE, MODE, ACCESS_MEM, RW_MEM, PARALLEL_LOAD, Tx_DATA, BUSY, ERROR;
    logic [7:0] MEM_ADDR;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_burst_controller dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .INPUT_KEY     (INPUT_KEY),
        .KEY_VALID     (KEY_VALID),
        .VALID_CMD     (VALID_CMD),
        .RW            (RW),
        .START_ADDR    (START_ADDR),
        .BURST_LEN     (BURST_LEN),
        .Tx_DONE       (Tx_DONE),
        .ACTIVE        (ACTIVE),
        .MODE          (MODE),
        .ACCESS_MEM    (ACCESS_MEM),
        .RW_MEM        (RW_MEM),
        .MEM_ADDR      (MEM_ADDR),
        .PARALLEL_LOAD (PARALLEL_LOAD),
        .Tx_DATA       (Tx_DATA),
        .BUSY          (BUSY),
        .ERROR         (ERROR)
    );

    always #5 CLK = ~CLK;

    // Event log sampled mid-cycle
    int         cyc    = 0;
    int         n_load = 0;
    int         n_txd  = 0;
    logic [7:0] acc_addr[$];
    bit         acc_rw[$];
    int         acc_cyc[$];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (ACCESS_MEM) begin
            acc_addr.push_back(MEM_ADDR);
            acc_rw.push_back(RW_MEM);
            acc_cyc.push_back(cyc);
        end
        if (PARALLEL_LOAD) n_load <= n_load + 1;
        if (Tx_DATA)       n_txd  <= n_txd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_key(input logic b);
        INPUT_KEY = b;
        KEY_VALID = 1'b1;
        tick();
        KEY_VALID = 1'b0;
    endtask

    task automatic send_cmd(input logic rw, input logic [7:0] addr, input logic [3:0] len);
        VALID_CMD  = 1'b1;
        RW         = rw;
        START_ADDR = addr;
        BURST_LEN  = len;
        tick();
        VALID_CMD  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_load, base_txd, dly, busy_cnt;
        bit done;

        RESET_N = 1'b0; INPUT_KEY = 1'b0; KEY_VALID = 1'b0; VALID_CMD = 1'b0;
        RW = 1'b0; START_ADDR = '0; BURST_LEN = '0; Tx_DONE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_active", ACTIVE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_access", ACCESS_MEM, 0);
        check("rst_error", ERROR, 0);
        RESET_N = 1'b1;
        tick();

        // Key decode 1011 then 0000
        send_key(1); send_key(0); send_key(1);
        check("key_3bits_active", ACTIVE, 0);
        send_key(1);
        check("key_mem_active", ACTIVE, 1);
        check("key_mem_mode", MODE, 1);
        send_key(0); send_key(0); send_key(0); send_key(0);
        check("key_off_active", ACTIVE, 0);
        check("key_off_mode", MODE, 0);
        send_key(1); send_key(0); send_key(1); send_key(1);
        check("key_mem2_active", ACTIVE, 1);

        // Read burst 0x10, 3 words, Tx_DONE returns 5 cycles after each load
        base_acc = acc_addr.size(); base_load = n_load; base_txd = n_txd;
        send_cmd(0, 8'h10, 4'd3);
        done = 0; dly = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (PARALLEL_LOAD) begin
                Tx_DONE = 1'b0; dly = 5;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) Tx_DONE = 1'b1;
            end
            if (!BUSY) done = 1;
            else tick();
        end
        check("rd_done", done, 1);
        check("rd_n_access", acc_addr.size() - base_acc, 3);
        check("rd_addr0", acc_addr[base_acc],   8'h10);
        check("rd_addr1", acc_addr[base_acc+1], 8'h11);
        check("rd_addr2", acc_addr[base_acc+2], 8'h12);
        check("rd_dir", {acc_rw[base_acc], acc_rw[base_acc+1], acc_rw[base_acc+2]}, 0);
        check("rd_n_load", n_load - base_load, 3);
        check("rd_n_txd", n_txd - base_txd, 3);
        check("rd_error", ERROR, 0);

        // Write burst 0xFF, 2 words, wraps to 0x00
        base_acc = acc_addr.size(); base_load = n_load;
        send_cmd(1, 8'hFF, 4'd2);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!BUSY) done = 1;
            else tick();
        end
        tick();
        check("wr_done", done, 1);
        check("wr_n_access", acc_addr.size() - base_acc, 2);
        check("wr_addr0", acc_addr[base_acc],   8'hFF);
        check("wr_addr1", acc_addr[base_acc+1], 8'h00);
        check("wr_dir", {acc_rw[base_acc], acc_rw[base_acc+1]}, 2'b11);
        check("wr_spacing", acc_cyc[base_acc+1] - acc_cyc[base_acc], 2);
        check("wr_n_load", n_load - base_load, 0);

        // Direct mode single load
        send_key(1); send_key(0); send_key(0); send_key(1);
        check("key_dir_mode", MODE, 0);
        check("key_dir_active", ACTIVE, 1);
        base_acc = acc_addr.size(); base_load = n_load;
        send_cmd(0, 8'h00, 4'd0);
        done = 0; dly = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (PARALLEL_LOAD) begin
                Tx_DONE = 1'b0; dly = 3;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) Tx_DONE = 1'b1;
            end
            if (!BUSY) done = 1;
            else tick();
        end
        tick();
        check("dir_done", done, 1);
        check("dir_n_load", n_load - base_load, 1);
        check("dir_n_access", acc_addr.size() - base_acc, 0);
        check("dir_error", ERROR, 0);

        // Direct mode timeout: Tx_DONE held low for 300 cycles
        send_cmd(0, 8'h00, 4'd0);
        busy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (PARALLEL_LOAD) Tx_DONE = 1'b0;
            if (BUSY) busy_cnt++;
            tick();
        end
        check("tmo_busy_cycles", busy_cnt, 256);
        check("tmo_error", ERROR, 1);
        check("tmo_busy", BUSY, 0);
        Tx_DONE = 1'b1;
        repeat (3) tick();
        check("tmo_error_sticky", ERROR, 1);

        // Mid-burst abort with key 0000 during WAIT
        send_key(1); send_key(0); send_key(1); send_key(1);
        base_acc = acc_addr.size();
        send_cmd(0, 8'h40, 4'd4);
        check("abort_error_cleared", ERROR, 0);
        for (int i = 0; i < 10 && !PARALLEL_LOAD; i++) tick();
        Tx_DONE = 1'b0;
        repeat (2) tick();
        send_key(0);
        check("abort_active", ACTIVE, 0);
        check("abort_busy_hold", BUSY, 1);
        tick();
        check("abort_busy", BUSY, 0);
        Tx_DONE = 1'b1;
        repeat (10) tick();
        check("abort_n_access", acc_addr.size() - base_acc, 1);
        check("abort_error", ERROR, 0);

        // Asynchronous reset during LOAD
        send_key(1); send_key(0); send_key(1); send_key(1);
        send_cmd(0, 8'h20, 4'd1);
        for (int i = 0; i < 10 && !PARALLEL_LOAD; i++) tick();
        check("rst_saw_load", PARALLEL_LOAD, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_load", PARALLEL_LOAD, 0);
        check("arst_txd", Tx_DATA, 0);
        check("arst_busy", BUSY, 0);
        check("arst_active", ACTIVE, 0);
        check("arst_addr", MEM_ADDR, 0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        tick();
        base_acc = acc_addr.size();
        send_cmd(0, 8'h30, 4'd2);
        repeat (3) tick();
        check("post_rst_ignored_busy", BUSY, 0);
        check("post_rst_n_access", acc_addr.size() - base_acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
